// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the regfile write-back scheduler.
package regfile_wb_sched_pkg;

  localparam int unsigned REG_BUS_W  = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_NUM    = 32;

  // Write-back requester index; also the encoding of the arbiter's last_grant flop.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the ALU and LSU write-back requesters.
module rr_arb2
  import regfile_wb_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  wb_req_e last_grant;

  // Grants are suppressed during reset; on a tie the side opposite last_grant wins.
  always_comb begin
    gnt_alu = 1'b0;
    gnt_lsu = 1'b0;
    if (!rst) begin
      if (req_alu && req_lsu) begin
        if (last_grant == WB_LSU) gnt_alu = 1'b1;
        else                      gnt_lsu = 1'b1;
      end else begin
        gnt_alu = req_alu;
        gnt_lsu = req_lsu;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= WB_LSU;
    else if (gnt_alu) last_grant <= WB_ALU;
    else if (gnt_lsu) last_grant <= WB_LSU;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Regfile write-port scheduler: round-robin ALU/LSU write-back, busy scoreboard and issue hazard check.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int unsigned XLEN   = REG_BUS_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned NREG   = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic              issue_re1_i,
  input  logic              issue_re2_i,
  input  logic              issue_we_i,
  input  logic [ADDR_W-1:0] issue_rs1_i,
  input  logic [ADDR_W-1:0] issue_rs2_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [XLEN-1:0]   alu_wdata_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_waddr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              we_o_reg,
  output logic [ADDR_W-1:0] waddr_o_reg,
  output logic [XLEN-1:0]   wdata_o_reg,
  output logic [NREG-1:0]   busy_o,
  output logic              wb_err_o
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              gnt_alu;
  logic              gnt_lsu;
  logic              wb_hs;
  logic [ADDR_W-1:0] sel_waddr;
  logic [XLEN-1:0]   sel_wdata;
  logic              issue_set;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_valid_i),
    .req_lsu (lsu_valid_i),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu)
  );

  assign alu_ready_o = gnt_alu;
  assign lsu_ready_o = gnt_lsu;
  assign wb_hs       = gnt_alu | gnt_lsu;
  assign sel_waddr   = gnt_lsu ? lsu_waddr_i : alu_waddr_i;
  assign sel_wdata   = gnt_lsu ? lsu_wdata_i : alu_wdata_i;

  always_comb begin
    issue_ready_o = !rst
                  && !(issue_re1_i && busy[issue_rs1_i])
                  && !(issue_re2_i && busy[issue_rs2_i])
                  && !(issue_we_i  && busy[issue_rd_i]);
  end

  assign issue_set = issue_valid_i && issue_ready_o && issue_we_i && (issue_rd_i != '0);

  // A bit being cleared is still busy, so WAW keeps issue from setting it in the same cycle.
  always_comb begin
    busy_nxt = busy;
    if (we_o_reg)  busy_nxt[waddr_o_reg] = 1'b0;
    if (issue_set) busy_nxt[issue_rd_i]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_o = busy;

  // Write stage: one registered slot, drained every cycle; x0 handshakes complete without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o_reg    <= 1'b0;
      waddr_o_reg <= '0;
      wdata_o_reg <= '0;
      wb_err_o    <= 1'b0;
    end else begin
      we_o_reg <= wb_hs && (sel_waddr != '0);
      wb_err_o <= wb_hs && (sel_waddr != '0) && !busy[sel_waddr];
      if (wb_hs) begin
        waddr_o_reg <= sel_waddr;
        wdata_o_reg <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a write-stage scoreboard queue.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_ready_o, issue_re1_i, issue_re2_i, issue_we_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_waddr_i;
  logic [63:0] alu_wdata_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_waddr_i;
  logic [63:0] lsu_wdata_i;
  logic        we_o_reg;
  logic [4:0]  waddr_o_reg;
  logic [63:0] wdata_o_reg;
  logic [31:0] busy_o;
  logic        wb_err_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        err;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_sched #(.XLEN(64), .ADDR_W(5), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid_i),
    .issue_ready_o (issue_ready_o),
    .issue_re1_i   (issue_re1_i),
    .issue_re2_i   (issue_re2_i),
    .issue_we_i    (issue_we_i),
    .issue_rs1_i   (issue_rs1_i),
    .issue_rs2_i   (issue_rs2_i),
    .issue_rd_i    (issue_rd_i),
    .alu_valid_i   (alu_valid_i),
    .alu_ready_o   (alu_ready_o),
    .alu_waddr_i   (alu_waddr_i),
    .alu_wdata_i   (alu_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_ready_o   (lsu_ready_o),
    .lsu_waddr_i   (lsu_waddr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .we_o_reg      (we_o_reg),
    .waddr_o_reg   (waddr_o_reg),
    .wdata_o_reg   (wdata_o_reg),
    .busy_o        (busy_o),
    .wb_err_o      (wb_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: check combinational readys mid-cycle, queue the expected write-stage
  // result, then pop and compare it just after the edge.
  task automatic tick(input logic e_alu, input logic e_lsu, input logic e_iss, input logic e_err);
    wr_t w;
    @(negedge clk);
    chk("alu_ready", alu_ready_o, e_alu);
    chk("lsu_ready", lsu_ready_o, e_lsu);
    chk("issue_ready", issue_ready_o, e_iss);
    w.we = 1'b0; w.addr = '0; w.data = '0; w.err = e_err;
    if (e_alu) begin
      w.addr = alu_waddr_i; w.data = alu_wdata_i; w.we = (alu_waddr_i != 5'd0);
    end else if (e_lsu) begin
      w.addr = lsu_waddr_i; w.data = lsu_wdata_i; w.we = (lsu_waddr_i != 5'd0);
    end
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      w = exp_q.pop_front();
      chk("we_o_reg", we_o_reg, w.we);
      if (w.we) begin
        chk("waddr_o_reg", waddr_o_reg, w.addr);
        chk("wdata_o_reg", wdata_o_reg, w.data);
      end
      chk("wb_err_o", wb_err_o, w.err);
    end
  endtask

  initial begin
    rst = 1'b1;
    issue_valid_i = 1'b1; issue_re1_i = 1'b0; issue_re2_i = 1'b0; issue_we_i = 1'b1;
    issue_rs1_i = '0; issue_rs2_i = '0; issue_rd_i = 5'd5;
    alu_valid_i = 1'b1; alu_waddr_i = 5'd1; alu_wdata_i = 64'hA1;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd2; lsu_wdata_i = 64'hB2;

    // Reset with every valid high: no readys, no writes, no busy bits.
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_after_reset", busy_o, 32'h0);
    rst = 1'b0; issue_valid_i = 1'b0; issue_we_i = 1'b0;

    // Tie right after reset: ALU, LSU, ALU, LSU. None of the targets are busy.
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    alu_waddr_i = 5'd3; alu_wdata_i = 64'hA3;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    lsu_waddr_i = 5'd4; lsu_wdata_i = 64'hB4;
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    chk("busy_after_tie", busy_o, 32'h0);

    // Issue rd=5, then ALU write-back of x5.
    issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd5;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    issue_valid_i = 1'b0; issue_we_i = 1'b0;
    chk("busy_x5_set", busy_o, 32'h20);
    alu_valid_i = 1'b1; alu_waddr_i = 5'd5; alu_wdata_i = 64'hDEAD;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    alu_valid_i = 1'b0;
    chk("busy_x5_n1", busy_o, 32'h20);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_x5_n2", busy_o, 32'h0);

    // RAW stall on x7 until N+2 after its write-back.
    issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd7;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_x7_set", busy_o, 32'h80);
    issue_we_i = 1'b0; issue_re1_i = 1'b1; issue_rs1_i = 5'd7;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    alu_valid_i = 1'b1; alu_waddr_i = 5'd7; alu_wdata_i = 64'h7777;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    alu_valid_i = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    issue_valid_i = 1'b0; issue_re1_i = 1'b0;
    chk("busy_x7_clear", busy_o, 32'h0);

    // Write-back to x0: handshake completes, no write, no error.
    alu_valid_i = 1'b1; alu_waddr_i = 5'd0; alu_wdata_i = 64'hFFFF;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    alu_valid_i = 1'b0;
    chk("busy_x0", busy_o, 32'h0);

    // LSU write-back to non-busy x9: write happens, single-cycle error pulse.
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 64'h9999;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    lsu_valid_i = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-stall drops the busy bit; arbiter returns to ALU-first.
    issue_valid_i = 1'b1; issue_we_i = 1'b1; issue_rd_i = 5'd10;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("busy_x10_set", busy_o, 32'h400);
    issue_we_i = 1'b0; issue_re2_i = 1'b1; issue_rs2_i = 5'd10;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; alu_valid_i = 1'b1; alu_waddr_i = 5'd12; alu_wdata_i = 64'hC12;
    lsu_valid_i = 1'b1; lsu_waddr_i = 5'd13; lsu_wdata_i = 64'hD13;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("busy_mid_reset", busy_o, 32'h0);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    alu_valid_i = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    lsu_valid_i = 1'b0; issue_valid_i = 1'b0; issue_re2_i = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
